// File: rtl/i2s_tx.sv
// i2s_tx: master-mode I2S transmitter with a one-entry valid/ready holding buffer.
// Ports: sclk/rst (async, active-high) clock and reset; en run request sampled at frame
// boundaries; in_valid/in_ready/left_in/right_in sample-pair handshake; lrclk word select
// (0 = left); sdata serial data, MSB first with one-bit delay; underrun pulse on empty load.
module i2s_tx #(
    parameter int DATA_W = 16
) (
    input  logic              sclk,
    input  logic              rst,
    input  logic              en,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] left_in,
    input  logic [DATA_W-1:0] right_in,
    output logic              lrclk,
    output logic              sdata,
    output logic              underrun
);
    localparam int CW = $clog2(2 * DATA_W);
    localparam logic [CW-1:0] LAST = CW'(2 * DATA_W - 1);
    localparam logic [CW-1:0] HALF = CW'(DATA_W);
    localparam logic [CW-1:0] ONE  = CW'(1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic                hold_full_q, hold_full_d;
    logic [DATA_W-1:0]   hold_l_q, hold_l_d, hold_r_q, hold_r_d;
    logic [2*DATA_W-1:0] shift_q, shift_d, frame;
    logic                lrclk_q, lrclk_d, sdata_q, sdata_d, underrun_q, underrun_d;
    logic                accept, load, busy;

    assign in_ready = !hold_full_q;
    assign lrclk    = lrclk_q;
    assign sdata    = sdata_q;
    assign underrun = underrun_q;

    assign accept = in_valid && !hold_full_q;
    // A load happens on the IDLE->RUN edge or at every frame boundary while enabled.
    assign load   = en && ((state_q == IDLE) ? hold_full_q : (cnt_q == '0));
    assign busy   = (state_q == RUN) && (cnt_q != '0);
    // An empty buffer at load time sends a silent frame; an accept on the same edge lands in hold.
    assign frame  = hold_full_q ? {hold_l_q, hold_r_q} : '0;

    always_ff @(posedge sclk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            hold_full_q <= 1'b0;
            hold_l_q    <= '0;
            hold_r_q    <= '0;
            shift_q     <= '0;
            lrclk_q     <= 1'b0;
            sdata_q     <= 1'b0;
            underrun_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            hold_full_q <= hold_full_d;
            hold_l_q    <= hold_l_d;
            hold_r_q    <= hold_r_d;
            shift_q     <= shift_d;
            lrclk_q     <= lrclk_d;
            sdata_q     <= sdata_d;
            underrun_q  <= underrun_d;
        end
    end

    always_comb begin
        state_d = load ? RUN : (cnt_q == '0) ? IDLE : state_q;
    end

    always_comb begin
        cnt_d       = load ? ONE : busy ? ((cnt_q == LAST) ? '0 : cnt_q + ONE) : '0;
        // The shifter holds the bits still to come; its MSB is the next bit on the line.
        shift_d     = load ? (frame << 1) : (shift_q << 1);
        sdata_d     = load ? frame[2*DATA_W-1] : busy ? shift_q[2*DATA_W-1] : 1'b0;
        lrclk_d     = cnt_d >= HALF;
        underrun_d  = load && !hold_full_q;
        hold_full_d = (load && hold_full_q) ? 1'b0 : accept ? 1'b1 : hold_full_q;
        hold_l_d    = accept ? left_in : hold_l_q;
        hold_r_d    = accept ? right_in : hold_r_q;
    end
endmodule

// File: doc/i2s_tx.md
# i2s_tx

Master-mode I2S transmitter, the send-side counterpart of the stereo I2S receiver. Accepts 16-bit left/right sample pairs through a valid/ready handshake into a one-entry holding buffer. Generates `lrclk` from `sclk` and serialises each pair MSB-first with the standard one-bit I2S delay, so the team's receiver reconstructs it bit-exactly. Sits between the audio processing pipeline and the DAC / codec serial port.

## Interface
- `DATA_W`, default 16: bits per channel slot; the frame is `2*DATA_W` sclk cycles. Must equal the receiver word width.
- `sclk`  in  1  bit clock; the only clock. All state and outputs update on its posedge.
- `rst`  in  1  reset; asynchronous, active-high.
- `en`  in  1  run request; sampled only at frame boundaries.
- `in_valid`  in  1  sample pair offered.
- `in_ready`  out  1  holding buffer empty (`!hold_full`); combinational from a register.
- `left_in`  in  DATA_W  left sample.
- `right_in`  in  DATA_W  right sample.
- `lrclk`  out  1  word select: 0 = left slot, 1 = right slot; registered.
- `sdata`  out  1  serial data; registered.
- `underrun`  out  1  one-cycle pulse: a frame started with an empty buffer.

## Operation
- Handshake: the pair is accepted on the posedge where `in_valid && in_ready`, and `hold_full` sets.
  - Inputs may change freely when not accepted.
  - Only a frame load clears `hold_full`.
- Bit counter `cnt` runs 0..2N-1, where N = DATA_W, and wraps to 0.
- States:
  - IDLE: `cnt`=0, `lrclk`=0, `sdata`=0.
  - RUN: counting.
- IDLE→RUN when `en && hold_full` at a posedge.
  - That edge is a load event.
  - `cnt` becomes 1.
- RUN, `cnt`≠0: `cnt` increments.
- RUN, `cnt`==0 at the posedge:
  - `en`=1: load event; `cnt` becomes 1.
  - `en`=0: go to IDLE, `cnt` stays 0.
- Load event:
  - If `hold_full`: the frame register takes hold L/R and `hold_full` clears.
  - Otherwise (RUN only): the frame is L=R=0 and `underrun`=1 for the following cycle.
- Output for the cycle with `cnt`=c in RUN:
  - `lrclk` = (c ≥ N).
  - c=1..N: `sdata` = left[N-c]; the MSB is at c=1.
  - c=N+1..2N-1: `sdata` = right[2N-c].
  - c=0: `sdata` = right[0] of the previous frame.
- Simultaneous accept and load, possible only with the buffer empty:
  - The load sees the empty buffer and sends zeros with `underrun`.
  - The newly accepted pair stays in hold for the next frame.
- Reset mid-frame: immediately IDLE.
  - The current frame is truncated and the hold contents are discarded.

## Timing
- Reset values:
  - State IDLE, `cnt`=0, `lrclk`=0, `sdata`=0, `underrun`=0.
  - `hold_full`=0, so `in_ready`=1.
  - Handshakes are ignored while `rst`=1.
- Accept to first bit:
  - Accept at edge a in IDLE with `en`=1.
  - Edge a+1 is the load; the left MSB is on `sdata` after edge a+1.
- Frame period is exactly 2N cycles in steady state.
  - `lrclk` falls every 2N cycles.
  - The right LSB is on the line during the first `lrclk`=0 cycle.
- `in_ready` returns to 1 the cycle after each load.
  - A producer that answers within 2N-1 cycles never underruns.
- Deasserting `en` mid-frame finishes the frame, including the trailing right LSB, then idles.
  - `lrclk` stays 0 and `sdata` stays 0 in IDLE.
- `underrun` is high for exactly one cycle per empty-buffer load, coincident with `cnt`=1.

## Test plan
- Reset, then `en`=1 and offer L=0xA5C3, R=0x1234. Check:
  - `in_ready` drops for one cycle.
  - `sdata` over `cnt` 1..16 is 1010010111000011.
  - `sdata` over `cnt` 17..31 then 0 is 0001001000110100.
  - A looped-back receiver shows `left_chan`=0xA5C3 and `right_chan`=0x1234 after the falling `lrclk` edge.
- Stream the pairs (0x8000,0x7FFF), (0x0001,0xFFFF), (0xFFFF,0x0000) back-to-back. Check:
  - `lrclk` period is 32 cycles with no gaps.
  - The receiver sees the three pairs in order.
  - `underrun` never asserts.
- Load one pair and then withhold `in_valid`. Check:
  - The next frame transmits all zeros with `lrclk` still toggling.
  - `underrun` pulses once at its `cnt`=1.
- Drop `en` at `cnt`=10 with a pair waiting in hold. Check:
  - The current frame completes, including the right LSB at `cnt`=0.
  - The block then enters IDLE with `lrclk`=0 and `sdata`=0.
  - The held pair is retained; when `en` returns it is sent and `in_ready`=1.
- Assert `rst` asynchronously at `cnt`=20 with the buffer full. Check:
  - `lrclk`, `sdata`, `underrun` go to 0 and `in_ready` goes to 1 without waiting for a clock edge.
  - After release, no frame starts until a new pair is accepted.
- Offer a pair on the same edge as an empty-buffer load. Check:
  - That frame is zeros with `underrun`.
  - The offered pair goes out in the following frame.
